udma_evt_collector: RTL
=======================

UDMA_EVT_COLLECTOR -- requirements
Module: udma_evt_collector

Interface
REQ-001 SHALL have parameter N_EVENTS, default 32, number of peripheral event sources; legal range 1..256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of queued event IDs; power of two, at least 2.
REQ-003 clk_i  in  1  single clock; all state on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 evt_i  in  N_EVENTS  one-cycle event pulses, one bit per source.
REQ-006 event_valid_o  out  1  queued event available; drives the uDMA core's event_valid_i.
REQ-007 event_data_o  out  8  source index of head event, zero-extended; drives the core's event_data_i.
REQ-008 event_ready_i  in  1  consumer accepts the head event; from the core's event_ready_o.
REQ-009 ovf_o  out  1  sticky flag, at least one event was lost.
REQ-010 drop_cnt_o  out  8  saturating count of lost events.
REQ-011 ovf_clr_i  in  1  synchronous clear of ovf_o and drop_cnt_o.

Function
REQ-012 SHALL keep one pending bit per source; a high evt_i[k] sets pending[k] at the next edge.
REQ-013 SHALL count an event as lost when evt_i[k] is high while pending[k] is set and not granted in that cycle; pending[k] stays set.
REQ-014 Each lost event SHALL set ovf_o and add 1 to drop_cnt_o, saturating at 255.
REQ-015 Multiple losses in one cycle SHALL add their count to drop_cnt_o, saturating at 255.
REQ-016 evt_i[k] high in the same cycle pending[k] is granted SHALL leave pending[k] set; this is not a loss.
REQ-017 Each cycle with any pending bit and FIFO count < FIFO_DEPTH, the round-robin arbiter SHALL grant exactly one source.
REQ-018 On a grant, the source index SHALL be pushed into the FIFO and its pending bit cleared.
REQ-019 Round-robin: search starts at pointer rr_ptr and wraps through N_EVENTS-1 to 0.
REQ-020 After a grant to index g, rr_ptr SHALL become (g+1) mod N_EVENTS; with no grant, rr_ptr is unchanged.
REQ-021 With the FIFO full (count == FIFO_DEPTH), no grant SHALL occur, even if a pop happens in the same cycle.
REQ-022 event_valid_o SHALL equal FIFO not empty; event_data_o SHALL be the FIFO head, registered, with no combinational path from evt_i.
REQ-023 A pop SHALL occur on event_valid_o and event_ready_i both high; head data SHALL hold stable while valid and not ready.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged.
REQ-025 Latency: evt_i pulse at edge k -> pending at k -> FIFO push at k+1 -> event_valid_o high after k+1, given an empty FIFO and no competing pending bits.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-027 ovf_clr_i SHALL clear ovf_o and drop_cnt_o; a loss in the same cycle wins: ovf_o=1, drop_cnt_o=number lost that cycle.

Reset
REQ-028 While rstn_i is low, the block SHALL hold: pending=0, rr_ptr=0, FIFO empty, event_valid_o=0, event_data_o=0, ovf_o=0, drop_cnt_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and pending events without raising ovf_o.
REQ-030 evt_i SHALL be ignored while rstn_i is low.

Structure
REQ-031 EVT_DATA_WIDTH (8) and EVT_FIFO_DEPTH default (4) SHALL live in udma_pkg.
REQ-032 The round-robin arbiter SHALL be a sub-module, udma_evt_rr_arb: request vector and pointer in, grant valid and index out, purely combinational.
REQ-033 The FIFO SHALL be inline register storage; no memory macro.

Verification
REQ-034 Single event: evt_i[5] pulse at cycle 10, ready=1 -> event_valid_o=1 with data 0x05 after edge 11; popped at edge 12; ovf_o=0.
REQ-035 Round-robin: evt_i[3], [7] and [1] pulsed in the same cycle, rr_ptr=2 -> output order 3, 7, 1; rr_ptr ends at 2.
REQ-036 Backpressure: ready=0, pulse sources 0..5 one per cycle -> 4 queued (IDs 0,1,2,3), sources 4 and 5 stay pending, no loss; ready=1 -> drains 0,1,2,3,4,5.
REQ-037 Loss: ready=0, FIFO full, evt_i[9] pulsed 3 times -> drop_cnt_o=2, ovf_o=1; ovf_clr_i pulse -> both 0.
REQ-038 Saturation and collision: 300 losses -> drop_cnt_o=255; ovf_clr_i together with 1 loss -> drop_cnt_o=1, ovf_o=1.
REQ-039 Reset mid-stream: 3 queued and 2 pending, rstn_i low for 1 cycle -> event_valid_o=0, all outputs 0, no later stale events.

Source files
------------

// File: rtl/udma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_pkg: shared widths, defaults and helpers for the uDMA event path |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package udma_pkg;

    localparam int EVT_DATA_WIDTH = 8;
    localparam int EVT_FIFO_DEPTH = 4;

    // Saturating accumulate for the 8-bit drop counter; inc may reach 256.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [8:0] inc);
        logic [9:0] sum;
        sum = {2'b00, base} + {1'b0, inc};
        return (sum > 10'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/udma_evt_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_evt_rr_arb: combinational round-robin pick starting at ptr_i     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module udma_evt_rr_arb #(
    parameter int N_REQ = 32,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [PTR_W-1:0] gnt_idx_o
);

    logic             hi_hit;
    logic             lo_hit;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;

    // Scanning downward leaves the lowest match in each half: hi covers
    // indices at/above the pointer, lo covers the wrapped-around range.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_hit = 1'b1;
                lo_idx = PTR_W'(j);
                if (j >= int'(ptr_i)) begin
                    hi_hit = 1'b1;
                    hi_idx = PTR_W'(j);
                end
            end
        end
        gnt_valid_o = lo_hit;
        gnt_idx_o   = hi_hit ? hi_idx : lo_idx;
    end

endmodule
`default_nettype wire

// File: rtl/udma_evt_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_evt_collector: latches peripheral event pulses, arbitrates them  |
// | into a small ID FIFO for the uDMA core and tracks lost events.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module udma_evt_collector
    import udma_pkg::*;
#(
    parameter int N_EVENTS   = 32,
    parameter int FIFO_DEPTH = EVT_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [N_EVENTS-1:0]       evt_i,
    output logic                      event_valid_o,
    output logic [EVT_DATA_WIDTH-1:0] event_data_o,
    input  logic                      event_ready_i,
    output logic                      ovf_o,
    output logic [7:0]                drop_cnt_o,
    input  logic                      ovf_clr_i
);

    localparam int IDX_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [N_EVENTS-1:0]       pending_q, pending_d, gnt_onehot;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [EVT_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [EVT_DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic [7:0]                drop_cnt_q, drop_cnt_d;
    logic                      gnt_valid, fifo_full, push, pop;
    logic [8:0]                n_lost;

    udma_evt_rr_arb #(
        .N_REQ (N_EVENTS),
        .PTR_W (IDX_W)
    ) u_rr_arb (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle does not free a slot for the arbiter.
        push      = gnt_valid && !fifo_full;
        pop       = (count_q != '0) && event_ready_i;

        n_lost     = '0;
        gnt_onehot = '0;
        for (int k = 0; k < N_EVENTS; k++) begin
            gnt_onehot[k] = push && (gnt_idx == IDX_W'(k));
            if (evt_i[k] && pending_q[k] && !(push && (gnt_idx == IDX_W'(k))))
                n_lost = n_lost + 9'd1;
        end

        pending_d = (pending_q & ~gnt_onehot) | evt_i;

        rr_ptr_d = rr_ptr_q;
        if (push)
            rr_ptr_d = (gnt_idx == IDX_W'(N_EVENTS - 1)) ? '0 : gnt_idx + IDX_W'(1);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = EVT_DATA_WIDTH'(gnt_idx);
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        // A loss in the clearing cycle survives the clear.
        drop_cnt_d = sat_add8(ovf_clr_i ? 8'd0 : drop_cnt_q, n_lost);
        ovf_d      = (ovf_q && !ovf_clr_i) || (n_lost != '0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign event_valid_o = (count_q != '0);
    assign event_data_o  = mem_q[rd_ptr_q];
    assign ovf_o         = ovf_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire
